// File: rtl/reg_scoreboard_pkg.sv
// ============================================================================
// Module  : reg_scoreboard_pkg
// Purpose : Shared defaults and types for the register scoreboard slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;

    // Default register address width (tracks 2**DEF_REG_AW registers)
    localparam int DEF_REG_AW = 5;
    // Default per-register pending counter width
    localparam int DEF_CNT_W  = 2;
    // Hard-wired zero register, never tracked
    localparam int REG_ZERO   = 0;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard_counter.sv
// ============================================================================
// Module  : scb_counter
// Purpose : Saturating up/down pending-write counter for one register.
//           Simultaneous inc and dec cancel; clr empties the counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nz_o,
    output logic             full_o,
    output logic             uflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, cancel on inc+dec, saturate at both ends
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign nz_o    = (cnt_q != '0);
    assign full_o  = (cnt_q == CNT_MAX);
    assign uflow_o = dec_i && !inc_i && !clr_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module  : reg_scoreboard
// Purpose : Tracks register writes in flight between issue and commit and
//           withholds issue while an instruction's sources are pending.
//           Optional macro SCB_BYPASS_EN: a source whose last pending write
//           commits this cycle is treated as ready (write-through read).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_valid_i,
    output logic                 iss_ready_o,
    input  logic [REG_AW-1:0]    iss_rs_i,
    input  logic                 iss_rs_use_i,
    input  logic [REG_AW-1:0]    iss_rt_i,
    input  logic                 iss_rt_use_i,
    input  logic                 iss_we_i,
    input  logic [REG_AW-1:0]    iss_wa_i,
    input  logic                 cmt_we_i,
    input  logic [REG_AW-1:0]    cmt_wa_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic [2**REG_AW-1:0] pending_mask_o,
    output logic                 busy_any_o,
    output logic                 err_o
);

    localparam int               NREG = 2**REG_AW;
    localparam logic [REG_AW-1:0] ZA  = REG_AW'(REG_ZERO);

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  nz_vec, full_vec, uflow_vec, inc_vec, dec_vec, ovf_vec;
    logic             hz_rs, hz_rt, dst_full, inc_ev, dec_ev, byp_rs, byp_rt;
    logic             err_q, err_d;

    // Register 0 is never tracked
    assign cnt[0]       = '0;
    assign nz_vec[0]    = 1'b0;
    assign full_vec[0]  = 1'b0;
    assign uflow_vec[0] = 1'b0;
    assign inc_vec[0]   = 1'b0;
    assign dec_vec[0]   = 1'b0;

    // Commits are ignored during a flush; issue is blocked by iss_ready
    assign dec_ev = cmt_we_i && (cmt_wa_i != ZA) && !flush_i;

`ifdef SCB_BYPASS_EN
    assign byp_rs = dec_ev && (cmt_wa_i == iss_rs_i) && (cnt[iss_rs_i] == CNT_W'(1));
    assign byp_rt = dec_ev && (cmt_wa_i == iss_rt_i) && (cnt[iss_rt_i] == CNT_W'(1));
`else
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
`endif

    assign hz_rs    = iss_rs_use_i && (iss_rs_i != ZA) && nz_vec[iss_rs_i] && !byp_rs;
    assign hz_rt    = iss_rt_use_i && (iss_rt_i != ZA) && nz_vec[iss_rt_i] && !byp_rt;
    assign dst_full = iss_we_i && (iss_wa_i != ZA) && full_vec[iss_wa_i];

    assign iss_ready_o = !hz_rs && !hz_rt && !dst_full && !flush_i;
    assign stall_o     = iss_valid_i && !iss_ready_o;
    assign inc_ev      = iss_valid_i && iss_ready_o && iss_we_i && (iss_wa_i != ZA);

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_cnt
            assign inc_vec[i] = inc_ev && (iss_wa_i == REG_AW'(i));
            assign dec_vec[i] = dec_ev && (cmt_wa_i == REG_AW'(i));

            scb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk     (clk),
                .reset   (reset),
                .inc_i   (inc_vec[i]),
                .dec_i   (dec_vec[i]),
                .clr_i   (flush_i),
                .cnt_o   (cnt[i]),
                .nz_o    (nz_vec[i]),
                .full_o  (full_vec[i]),
                .uflow_o (uflow_vec[i])
            );
        end
    endgenerate

    // An increment that would wrap; unreachable through issue, kept defensive
    assign ovf_vec = inc_vec & full_vec & ~dec_vec;

    // Sticky error accumulates any underflow or overflow attempt
    always_comb begin
        err_d = err_q | (|uflow_vec) | (|ovf_vec);
    end

    // Error register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign pending_mask_o = nz_vec;
    assign busy_any_o     = |nz_vec;
    assign err_o          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module  : tb_reg_scoreboard
// Purpose : Directed table-driven bench for reg_scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid, iss_ready, iss_rs_use, iss_rt_use, iss_we;
    logic [4:0]  iss_rs, iss_rt, iss_wa, cmt_wa;
    logic        cmt_we, flush, stall, busy_any, err;
    logic [31:0] pending_mask;

    int tests = 0;
    int fails = 0;

    reg_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .iss_valid_i    (iss_valid),
        .iss_ready_o    (iss_ready),
        .iss_rs_i       (iss_rs),
        .iss_rs_use_i   (iss_rs_use),
        .iss_rt_i       (iss_rt),
        .iss_rt_use_i   (iss_rt_use),
        .iss_we_i       (iss_we),
        .iss_wa_i       (iss_wa),
        .cmt_we_i       (cmt_we),
        .cmt_wa_i       (cmt_wa),
        .flush_i        (flush),
        .stall_o        (stall),
        .pending_mask_o (pending_mask),
        .busy_any_o     (busy_any),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic        rs_use;
        logic [4:0]  rt;
        logic        rt_use;
        logic        we;
        logic [4:0]  wa;
        logic        cwe;
        logic [4:0]  cwa;
        logic        fl;
        logic        exp_ready;   // combinational, before the edge
        logic [31:0] exp_mask;    // after the edge
        logic        exp_err;     // after the edge
    } vec_t;

    vec_t vecs [$];

`ifdef SCB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    function automatic vec_t mk(input logic v, input int rs, input logic rsu,
                                input int rt, input logic rtu, input logic we,
                                input int wa, input logic cwe, input int cwa,
                                input logic fl, input logic er, input logic [31:0] em,
                                input logic ee);
        vec_t t;
        t.valid = v;  t.rs = 5'(rs); t.rs_use = rsu; t.rt = 5'(rt); t.rt_use = rtu;
        t.we = we;    t.wa = 5'(wa); t.cwe = cwe;    t.cwa = 5'(cwa); t.fl = fl;
        t.exp_ready = er; t.exp_mask = em; t.exp_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        iss_valid = t.valid; iss_rs = t.rs; iss_rs_use = t.rs_use;
        iss_rt = t.rt; iss_rt_use = t.rt_use; iss_we = t.we; iss_wa = t.wa;
        cmt_we = t.cwe; cmt_wa = t.cwa; flush = t.fl;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    endtask

    initial begin
        //        v rs u rt u we wa cwe cwa fl  ready  mask      err
        vecs.push_back(mk(1, 3, 1, 4, 1, 1, 5, 0, 0, 0, 1,   32'h20,  0)); // first issue wa5
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   32'h20,  0)); // RAW on rs5
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, BYP, 32'h0,   0)); // commit 5
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1,   32'h0,   0)); // ready after commit
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1,   32'h80,  0)); // wa7 #1
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1,   32'h80,  0)); // wa7 #2
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1,   32'h80,  0)); // wa7 #3
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,   32'h80,  0)); // full
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0,   32'h80,  0)); // still full, commit 7
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1,   32'h80,  0)); // room again
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1,   32'h80,  0)); // drain 3->2
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1,   32'h80,  0)); // 2->1
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1,   32'h0,   0)); // 1->0
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1,   32'h200, 0)); // wa9
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 1,   32'h200, 0)); // inc+dec cancel
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1,   32'h0,   0)); // drain 9
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1,   32'h0,   0)); // r0 issue/use
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1,   32'h0,   0)); // r0 commit ignored
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1,   32'h20,  0)); // cnt5=1
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1,   32'h20,  0)); // cnt5=2
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 6, 1, 3, 0, 1,   32'h60,  1)); // cnt6=1, uflow on r3
        vecs.push_back(mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0,   32'h60,  1)); // RAW on rt6
        vecs.push_back(mk(1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1,   32'h60,  1)); // rt unused
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        iss_valid = 1'b1;
        #1;
        check("reset_mask",  pending_mask, 32'h0);
        check("reset_busy",  32'(busy_any), 32'h0);
        check("reset_ready", 32'(iss_ready), 32'h1);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_err",   32'(err), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_ready", i), 32'(iss_ready), 32'(vecs[i].exp_ready));
            check($sformatf("v%0d_stall", i), 32'(stall),
                  32'(vecs[i].valid && !vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_mask", i), pending_mask, vecs[i].exp_mask);
            check($sformatf("v%0d_busy", i), 32'(busy_any), 32'(vecs[i].exp_mask != 0));
            check($sformatf("v%0d_err", i),  32'(err), 32'(vecs[i].exp_err));
        end

        // Reset clears the sticky error left by the table
        @(negedge clk);
        reset = 1'b1; idle();
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        // Build cnt5=2, cnt6=1 then flush with a concurrent issue and commit
        drive(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0)); @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0)); @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1, 0, 0)); @(negedge clk);
        check("pre_flush_mask", pending_mask, 32'h60);
        check("pre_flush_err",  32'(err), 32'h0);
        drive(mk(1, 0, 0, 0, 0, 1, 8, 1, 5, 1, 0, 0, 0));
        #1;
        check("flush_ready", 32'(iss_ready), 32'h0);
        @(posedge clk); #1;
        check("flush_mask", pending_mask, 32'h0);
        check("flush_err",  32'(err), 32'h0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0));
        @(posedge clk); #1;
        check("post_flush_uflow", 32'(err), 32'h1);
        @(negedge clk); idle();
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'h1);

        // Reset mid-operation with events in flight
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 1, 12, 1, 11, 0, 1, 0, 0));
        @(posedge clk); #1;
        check("midreset_mask", pending_mask, 32'h0);
        check("midreset_err",  32'(err), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Commit-to-ready latency on a waiting reader, bounded wait
        drive(mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        drive(mk(1, 0, 0, 12, 1, 0, 0, 1, 12, 0, 0, 0, 0));
        begin
            int lat;
            lat = -1;
            for (int c = 0; c < 5 && lat < 0; c++) begin
                #1;
                if (iss_ready) lat = c;
                @(negedge clk);
                cmt_we = 1'b0;
            end
            check("reader_latency", 32'(lat), BYP ? 32'd0 : 32'd1);
        end
        idle();
        @(posedge clk); #1;
        check("final_mask", pending_mask, 32'h0);
        check("final_err",  32'(err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Read-side companion to the general register file. Tracks destination registers with writes in flight between issue (D stage) and register-file write commit (W stage), and stalls any instruction whose sources are still pending. Sits beside the decode stage. Consumes the same write-port signals (write enable, address) that drive the register file, and gates instruction issue with a valid/ready handshake.

Parameters:
REG_AW, 5, register address width; tracks 2**REG_AW registers.
CNT_W, 2, per-register pending counter width; at most 2**CNT_W-1 writes in flight per register.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
iss_valid  input  1  decode has an instruction to issue
iss_ready  output  1  issue accepted this cycle when iss_valid && iss_ready
iss_rs  input  REG_AW  source 1 address
iss_rs_use  input  1  source 1 is actually read
iss_rt  input  REG_AW  source 2 address
iss_rt_use  input  1  source 2 is actually read
iss_we  input  1  instruction will write a register
iss_wa  input  REG_AW  destination address
cmt_we  input  1  register-file write this cycle; same signal as the register file's write enable
cmt_wa  input  REG_AW  register-file write address
flush  input  1  discard all in-flight tracking
stall  output  1  iss_valid && !iss_ready
pending_mask  output  2**REG_AW  bit i set when cnt[i] != 0
busy_any  output  1  OR of pending_mask
err  output  1  sticky: counter underflow or overflow attempted

Behaviour:
- State: cnt[i], CNT_W bits, one per register; sticky err.
- Reset (synchronous): all cnt = 0, err = 0. Outputs after reset: pending_mask = 0, busy_any = 0, iss_ready = 1, stall = 0.
- Register 0 is never tracked: cnt[0] is held at 0; issue and commit to address 0 are ignored.
- Source hazard, per source s (rs or rt): hz_s = use_s && s != 0 && cnt[s] != 0, subject to the bypass rule under Optional Feature.
- Destination full: full = iss_we && iss_wa != 0 && cnt[iss_wa] == max.
- iss_ready = !hz_rs && !hz_rt && !full && !flush. Combinational, no latency.
- Issue event: inc = iss_valid && iss_ready && iss_we && iss_wa != 0.
- Commit event: dec = cmt_we && cmt_wa != 0.
- Counter update on the next clk edge:
  - inc and dec to the same register: cnt unchanged.
  - inc only: cnt + 1.
  - dec only: cnt - 1.
  - inc and dec to different registers: both apply independently.
- dec when cnt == 0: cnt stays 0, err set.
- full is never accepted, so overflow cannot occur via issue. err is also set if any increment would wrap (defensive).
- flush (synchronous): all cnt = 0 next cycle; issue blocked that cycle; a commit in the same cycle is ignored. After a flush, commits to a zero counter are still flagged as underflow. Controllers must flush only once the pipeline is drained of committing writers, or must mask cmt_we.
- reset has priority over flush. Reset mid-operation clears everything regardless of in-flight events.
- Issue and commit in the same cycle on unrelated registers never interact.

Optional Feature:
Macro SCB_BYPASS_EN.
- Defined: a source with cnt[s] == 1 that is being committed this cycle (dec && cmt_wa == s) is not a hazard, matching the register file's write-through read.
- Undefined: any nonzero cnt stalls. The source becomes ready one cycle after the commit.

Decomposition:
- Shared package: REG_AW and CNT_W defaults, constant REG_ZERO = 0, and a cnt_t typedef.
- One natural sub-module, scb_counter: a single saturating up/down counter with inc, dec and clr inputs and outputs cnt, nz, full and uflow. Instantiated 2**REG_AW - 1 times via generate.

Test Plan:
- Reset, then iss_valid with rs = 3, rt = 4 used, we = 1, wa = 5 -> iss_ready = 1; next cycle pending_mask = 0x20, busy_any = 1.
- Reader of rs = 5 while cnt[5] = 1, no commit -> stall = 1. Commit cmt_wa = 5:
  - Without SCB_BYPASS_EN: stall drops the cycle after.
  - With SCB_BYPASS_EN: stall drops in the commit cycle.
- Issue wa = 7 three times, no commits (CNT_W = 2) -> cnt[7] = 3. Fourth issue to wa = 7 -> iss_ready = 0. After one commit to 7 -> ready.
- Issue wa = 9 and commit wa = 9 in the same cycle with cnt[9] = 1 -> cnt[9] stays 1, mask bit 9 stays set.
- Issue wa = 0 and source rs = 0 with use = 1 -> never stalls, pending_mask bit 0 always 0.
- flush with cnt[5] = 2, cnt[6] = 1 -> next cycle pending_mask = 0, err = 0. A subsequent commit to 5 -> err = 1 and stays set until reset.
